// File: rtl/ysyx_23060059_wb_dcache.sv
// Write-back, write-allocate set-associative data cache with an AXI refill/writeback port.
// Define YSYX_23060059_DCACHE_PERF_EN to add internal hit/miss/writeback counters.
module ysyx_23060059_wb_dcache #(
  parameter int NSET      = 32,
  parameter int NWAY      = 4,
  parameter int BLK_BYTES = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic        req_we,
  input  logic [63:0] req_wdata,
  input  logic [7:0]  req_wstrb,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [63:0] resp_rdata,
  output logic [31:0] axi_araddr,
  output logic [7:0]  axi_arlen,
  output logic        axi_arvalid,
  input  logic        axi_arready,
  input  logic [63:0] axi_rdata,
  input  logic        axi_rvalid,
  output logic        axi_rready,
  input  logic        axi_rlast,
  output logic [31:0] axi_awaddr,
  output logic [7:0]  axi_awlen,
  output logic        axi_awvalid,
  input  logic        axi_awready,
  output logic [63:0] axi_wdata,
  output logic        axi_wvalid,
  input  logic        axi_wready,
  output logic        axi_wlast,
  input  logic        axi_bvalid,
  output logic        axi_bready
);
  localparam int BEATS  = BLK_BYTES / 8;
  localparam int OFF_W  = $clog2(BLK_BYTES);
  localparam int IDX_W  = $clog2(NSET);
  localparam int TAG_W  = 32 - OFF_W - IDX_W;
  localparam int WAY_W  = (NWAY > 1) ? $clog2(NWAY) : 1;
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  typedef enum logic [2:0] {IDLE, LOOKUP, WB_AW, WB_W, WB_B, RF_AR, RF_R, RESP} state_t;
  state_t state, state_nx;

  logic [31:0]       addr_q;
  logic              we_q;
  logic [63:0]       wdata_q;
  logic [7:0]        wstrb_q;
  logic [63:0]       rdata_q;
  logic [WAY_W-1:0]  way_q;
  logic [BEAT_W-1:0] beat_q;

  logic [TAG_W-1:0]             tag_arr  [NSET-1:0][NWAY-1:0];
  logic [63:0]                  data_arr [NSET-1:0][NWAY-1:0][BEATS-1:0];
  logic [NSET-1:0][NWAY-1:0]    vld_arr, dirty_arr;
  logic [NSET-1:0][WAY_W-1:0]   rr_arr;

  logic [TAG_W-1:0]  req_tag;
  logic [IDX_W-1:0]  req_idx;
  logic [BEAT_W-1:0] req_beat;
  assign req_tag = addr_q[31 -: TAG_W];
  assign req_idx = addr_q[OFF_W +: IDX_W];

  generate
    if (BEATS > 1) begin : g_beat
      assign req_beat = addr_q[3 +: BEAT_W];
    end else begin : g_beat1
      assign req_beat = '0;
    end
  endgenerate

  logic unused_ok;
  assign unused_ok = ^addr_q[2:0];

  function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] nw,
                                        input logic [7:0] strb);
    logic [63:0] res;
    for (int b = 0; b < 8; b++) res[8*b +: 8] = strb[b] ? nw[8*b +: 8] : old[8*b +: 8];
    return res;
  endfunction

  logic             hit, vic_dirty, last_beat;
  logic [WAY_W-1:0] hit_way, vic_way;
  logic [63:0]      hit_data;

  // Victim: lowest invalid way wins over the round-robin pointer (scan downward, last write wins).
  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    vic_way = rr_arr[req_idx];
    for (int w = 0; w < NWAY; w++)
      if (vld_arr[req_idx][w] && tag_arr[req_idx][w] == req_tag) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
    for (int w = NWAY - 1; w >= 0; w--)
      if (!vld_arr[req_idx][w]) vic_way = WAY_W'(w);
    vic_dirty = vld_arr[req_idx][vic_way] && dirty_arr[req_idx][vic_way];
    hit_data  = data_arr[req_idx][hit_way][req_beat];
    last_beat = (beat_q == BEAT_W'(BEATS - 1));
  end

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (req_valid) state_nx = LOOKUP;
      LOOKUP:  state_nx = hit ? RESP : (vic_dirty ? WB_AW : RF_AR);
      WB_AW:   if (axi_awready) state_nx = WB_W;
      WB_W:    if (axi_wready && last_beat) state_nx = WB_B;
      WB_B:    if (axi_bvalid) state_nx = RF_AR;
      RF_AR:   if (axi_arready) state_nx = RF_R;
      RF_R:    if (axi_rvalid && axi_rlast) state_nx = RESP;
      RESP:    if (resp_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      vld_arr   <= '0;
      dirty_arr <= '0;
      rr_arr    <= '0;
      rdata_q   <= '0;
      beat_q    <= '0;
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          addr_q  <= req_addr;
          we_q    <= req_we;
          wdata_q <= req_wdata;
          wstrb_q <= req_wstrb;
        end
        LOOKUP: begin
          beat_q <= '0;
          if (hit) begin
            way_q   <= hit_way;
            rdata_q <= we_q ? 64'd0 : hit_data;
            if (we_q) dirty_arr[req_idx][hit_way] <= 1'b1;
          end else begin
            way_q <= vic_way;
          end
        end
        WB_AW: if (axi_awready) beat_q <= '0;
        WB_W:  if (axi_wready) beat_q <= beat_q + 1'b1;
        RF_AR: if (axi_arready) beat_q <= '0;
        RF_R: if (axi_rvalid) begin
          beat_q <= beat_q + 1'b1;
          if (beat_q == req_beat) rdata_q <= we_q ? 64'd0 : axi_rdata;
          if (axi_rlast) begin
            tag_arr[req_idx][way_q]   <= req_tag;
            vld_arr[req_idx][way_q]   <= 1'b1;
            dirty_arr[req_idx][way_q] <= we_q;
            rr_arr[req_idx] <= (rr_arr[req_idx] == WAY_W'(NWAY - 1)) ? '0 : rr_arr[req_idx] + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // A store miss merges into the requested beat as it arrives, so the line lands already updated.
  always_ff @(posedge clock) begin
    if (state == LOOKUP && hit && we_q)
      data_arr[req_idx][hit_way][req_beat] <= merge(hit_data, wdata_q, wstrb_q);
    if (state == RF_R && axi_rvalid)
      data_arr[req_idx][way_q][beat_q] <= (we_q && beat_q == req_beat) ?
                                          merge(axi_rdata, wdata_q, wstrb_q) : axi_rdata;
  end

`ifdef YSYX_23060059_DCACHE_PERF_EN
  logic [31:0] hit_cnt, miss_cnt, wb_cnt;
  always_ff @(posedge clock) begin
    if (reset) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
      wb_cnt   <= '0;
    end else if (state == LOOKUP) begin
      if (hit) hit_cnt <= hit_cnt + 1'b1;
      else begin
        miss_cnt <= miss_cnt + 1'b1;
        if (vic_dirty) wb_cnt <= wb_cnt + 1'b1;
      end
    end
  end
  logic unused_perf;
  assign unused_perf = ^{hit_cnt, miss_cnt, wb_cnt};
`endif

  assign req_ready   = !reset && state == IDLE;
  assign resp_valid  = !reset && state == RESP;
  assign resp_rdata  = resp_valid ? rdata_q : 64'd0;
  assign axi_arvalid = !reset && state == RF_AR;
  assign axi_araddr  = {req_tag, req_idx, {OFF_W{1'b0}}};
  assign axi_arlen   = 8'(BEATS - 1);
  assign axi_rready  = !reset && state == RF_R;
  assign axi_awvalid = !reset && state == WB_AW;
  assign axi_awaddr  = {tag_arr[req_idx][way_q], req_idx, {OFF_W{1'b0}}};
  assign axi_awlen   = 8'(BEATS - 1);
  assign axi_wvalid  = !reset && state == WB_W;
  assign axi_wdata   = data_arr[req_idx][way_q][beat_q];
  assign axi_wlast   = axi_wvalid && last_beat;
  assign axi_bready  = !reset && state == WB_B;
endmodule

// File: tb/tb_ysyx_23060059_wb_dcache.sv
// Bench for ysyx_23060059_wb_dcache: random LSU traffic against a flat golden memory plus
// a tag-level cache model; an AXI slave process checks every AXI beat it sees.
module tb_ysyx_23060059_wb_dcache;
  localparam int NSET = 32, NWAY = 4, BLK = 16, BEATS = BLK / 8, OFF = 4, IB = 5;

  logic clock = 1'b0, reset;
  logic req_valid, req_ready, req_we, resp_valid, resp_ready;
  logic [31:0] req_addr, axi_araddr, axi_awaddr;
  logic [63:0] req_wdata, resp_rdata, axi_rdata, axi_wdata;
  logic [7:0]  req_wstrb, axi_arlen, axi_awlen;
  logic axi_arvalid, axi_arready, axi_rvalid, axi_rready, axi_rlast;
  logic axi_awvalid, axi_awready, axi_wvalid, axi_wready, axi_wlast, axi_bvalid, axi_bready;

  ysyx_23060059_wb_dcache #(.NSET(NSET), .NWAY(NWAY), .BLK_BYTES(BLK)) dut (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_we(req_we), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .axi_araddr(axi_araddr), .axi_arlen(axi_arlen), .axi_arvalid(axi_arvalid),
    .axi_arready(axi_arready), .axi_rdata(axi_rdata), .axi_rvalid(axi_rvalid),
    .axi_rready(axi_rready), .axi_rlast(axi_rlast), .axi_awaddr(axi_awaddr),
    .axi_awlen(axi_awlen), .axi_awvalid(axi_awvalid), .axi_awready(axi_awready),
    .axi_wdata(axi_wdata), .axi_wvalid(axi_wvalid), .axi_wready(axi_wready),
    .axi_wlast(axi_wlast), .axi_bvalid(axi_bvalid), .axi_bready(axi_bready));

  always #5 clock = ~clock;
  int cyc = 0;
  logic rst_q = 1'b1;
  always @(posedge clock) begin
    cyc   <= cyc + 1;
    rst_q <= reset;
  end

  int checks = 0, failures = 0;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // golden = what the CPU must observe; mem = what the AXI side really holds
  logic [63:0] gold [int unsigned];
  logic [63:0] mem  [int unsigned];
  function automatic logic [63:0] init_val(input int unsigned dw);
    return {dw, dw ^ 32'h5A5A5A5A};
  endfunction
  function automatic logic [63:0] gold_rd(input int unsigned dw);
    return gold.exists(dw) ? gold[dw] : init_val(dw);
  endfunction
  function automatic logic [63:0] mem_rd(input int unsigned dw);
    return mem.exists(dw) ? mem[dw] : init_val(dw);
  endfunction
  function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] nw,
                                        input logic [7:0] strb);
    logic [63:0] r;
    for (int b = 0; b < 8; b++) r[8*b +: 8] = strb[b] ? nw[8*b +: 8] : old[8*b +: 8];
    return r;
  endfunction

  int unsigned m_tag [NSET][NWAY];
  bit          m_vld [NSET][NWAY];
  bit          m_dty [NSET][NWAY];
  int          m_rr  [NSET];

  logic [31:0] exp_ar, exp_aw, last_ar, last_aw;
  logic [7:0]  last_arlen, last_awlen;
  int tx_ar, tx_aw, tx_w, tx_b;
  int ar_stall = 0, aw_stall = 0, w_stall = 0;
  bit hold_beat1 = 0;
  int w_beat;

  task automatic model_clear();
    for (int s = 0; s < NSET; s++) begin
      m_rr[s] = 0;
      for (int w = 0; w < NWAY; w++) begin m_vld[s][w] = 0; m_dty[s][w] = 0; end
    end
  endtask

  task automatic predict(input logic [31:0] a, input logic we, input logic [63:0] wd,
                         input logic [7:0] ws, output bit hit, output bit wb,
                         output logic [63:0] exp_rd);
    int idx, way;
    int unsigned tg, dw;
    bit found;
    idx = int'((a >> OFF) % NSET);
    tg  = a >> (OFF + IB);
    dw  = a >> 3;
    hit = 0; wb = 0; way = 0;
    for (int w = 0; w < NWAY; w++)
      if (m_vld[idx][w] && m_tag[idx][w] == tg) begin hit = 1; way = w; end
    if (!hit) begin
      found = 0;
      for (int w = 0; w < NWAY; w++)
        if (!found && !m_vld[idx][w]) begin found = 1; way = w; end
      if (!found) way = m_rr[idx];
      wb     = m_vld[idx][way] && m_dty[idx][way];
      exp_aw = 32'((m_tag[idx][way] << (OFF + IB)) | (idx << OFF));
      exp_ar = a & ~32'(BLK - 1);
      m_tag[idx][way] = tg; m_vld[idx][way] = 1; m_dty[idx][way] = 0;
      m_rr[idx] = (m_rr[idx] + 1) % NWAY;
    end
    exp_rd = we ? 64'd0 : gold_rd(dw);
    if (we) begin
      m_dty[idx][way] = 1;
      gold[dw] = merge(gold_rd(dw), wd, ws);
    end
  endtask

  // AXI slave + per-beat checker; all decisions made at negedge for the coming edge
  initial begin
    bit r_act = 0, b_act = 0, ar_seen = 0, aw_seen = 0, w_seen = 0;
    int r_beat = 0, ar_wait = 0, aw_wait = 0, w_wait = 0, b_dly = 0;
    logic [31:0] r_line = 0, w_line = 0, ar_a0 = 0, aw_a0 = 0;
    logic [63:0] w_d0 = 0;
    {axi_arready, axi_rvalid, axi_rlast, axi_awready, axi_wready, axi_bvalid} = '0;
    axi_rdata = '0;
    w_beat = 0;
    forever begin
      @(negedge clock);
      if (rst_q) begin
        r_act = 0; b_act = 0; ar_seen = 0; aw_seen = 0; w_seen = 0;
        ar_wait = 0; aw_wait = 0; w_wait = 0; w_beat = 0;
        {axi_arready, axi_rvalid, axi_rlast, axi_awready, axi_wready, axi_bvalid} = '0;
        continue;
      end
      if (r_act) begin
        axi_rvalid = ($urandom % 4) != 0;
        axi_rdata  = mem_rd(int'(r_line >> 3) + r_beat);
        axi_rlast  = (r_beat == BEATS - 1);
        if (axi_rvalid && axi_rready) begin
          r_beat++;
          if (r_beat == BEATS) r_act = 0;
        end
      end else begin
        axi_rvalid = ($urandom % 8) == 0;
        axi_rdata  = {$urandom, $urandom};
        axi_rlast  = 1'($urandom % 2);
      end
      axi_arready = 0;
      if (axi_arvalid) begin
        if (!ar_seen) begin
          ar_seen = 1; ar_a0 = axi_araddr; last_ar = axi_araddr; last_arlen = axi_arlen;
          chk("ar_addr", 64'(axi_araddr), 64'(exp_ar));
        end else chk("ar_addr_hold", 64'(axi_araddr), 64'(ar_a0));
        if (ar_wait >= ar_stall) begin
          axi_arready = 1; ar_seen = 0; ar_wait = 0;
          r_act = 1; r_line = axi_araddr; r_beat = 0; tx_ar++;
        end else ar_wait++;
      end else if (ar_seen) begin
        chk("ar_valid_dropped", 64'd0, 64'd1); ar_seen = 0;
      end
      if (b_act) begin
        axi_bvalid = (b_dly == 0);
        if (b_dly > 0) b_dly--;
        else if (axi_bready) begin b_act = 0; tx_b++; end
      end else axi_bvalid = ($urandom % 8) == 0;
      axi_wready = 0;
      if (axi_wvalid) begin
        if (!w_seen) begin w_seen = 1; w_d0 = axi_wdata; end
        else chk("w_data_hold", axi_wdata, w_d0);
        if (w_wait >= w_stall && !(hold_beat1 && w_beat == 1)) begin
          axi_wready = 1;
          chk("w_data", axi_wdata, gold_rd(int'(w_line >> 3) + w_beat));
          chk("w_last", 64'(axi_wlast), 64'(w_beat == BEATS - 1));
          mem[int'(w_line >> 3) + w_beat] = axi_wdata;
          if (axi_wlast) begin b_act = 1; b_dly = int'($urandom % 3); end
          w_beat++; tx_w++; w_seen = 0; w_wait = 0;
        end else w_wait++;
      end else if (w_seen) begin
        chk("w_valid_dropped", 64'd0, 64'd1); w_seen = 0;
      end
      axi_awready = 0;
      if (axi_awvalid) begin
        if (!aw_seen) begin
          aw_seen = 1; aw_a0 = axi_awaddr; last_aw = axi_awaddr; last_awlen = axi_awlen;
          chk("aw_addr", 64'(axi_awaddr), 64'(exp_aw));
        end else chk("aw_addr_hold", 64'(axi_awaddr), 64'(aw_a0));
        if (aw_wait >= aw_stall) begin
          axi_awready = 1; aw_seen = 0; aw_wait = 0;
          w_line = axi_awaddr; w_beat = 0; tx_aw++;
        end else aw_wait++;
      end else if (aw_seen) begin
        chk("aw_valid_dropped", 64'd0, 64'd1); aw_seen = 0;
      end
    end
  end

  task automatic do_req(input logic [31:0] a, input logic we, input logic [63:0] wd,
                        input logic [7:0] ws, input int hold,
                        output logic [63:0] rd, output int lat);
    bit hit, wb;
    logic [63:0] exp_rd;
    int n, acc;
    predict(a, we, wd, ws, hit, wb, exp_rd);
    tx_ar = 0; tx_aw = 0; tx_w = 0; tx_b = 0;
    rd = '0; lat = -1;
    req_addr = a; req_we = we; req_wdata = wd; req_wstrb = ws; req_valid = 1;
    n = 0;
    while (!req_ready && n < 50) begin @(negedge clock); n++; end
    if (!req_ready) begin
      chk("req_ready_timeout", 64'd0, 64'd1); req_valid = 0; return;
    end
    acc = cyc;
    @(negedge clock);
    req_valid = 0;
    n = 0;
    while (!resp_valid && n < 300) begin @(negedge clock); n++; end
    if (!resp_valid) begin chk("resp_timeout", 64'd0, 64'd1); return; end
    lat = cyc - acc;
    rd  = resp_rdata;
    if (hit) chk("hit_latency", 64'(lat), 64'd2);
    chk(we ? "store_rdata" : "load_rdata", resp_rdata, exp_rd);
    repeat (hold) begin
      @(negedge clock);
      chk("resp_valid_hold", 64'(resp_valid), 64'd1);
      chk("resp_rdata_hold", resp_rdata, rd);
    end
    resp_ready = 1;
    @(negedge clock);
    resp_ready = 0;
    chk("idle_after_resp", 64'({req_ready, resp_valid}), 64'b10);
    chk("ar_count", 64'(tx_ar), hit ? 64'd0 : 64'd1);
    chk("aw_count", 64'(tx_aw), 64'(wb));
    chk("w_count", 64'(tx_w), wb ? 64'(BEATS) : 64'd0);
    chk("b_count", 64'(tx_b), 64'(wb));
  endtask

  function automatic logic [8:0] all_vr();
    return {req_ready, resp_valid, axi_arvalid, axi_rready, axi_awvalid,
            axi_wvalid, axi_wlast, axi_bready, |resp_rdata};
  endfunction

  initial begin
    logic [63:0] rd;
    int lat, n;
    bit hit, wb;
    logic [63:0] exp_rd;
    logic [31:0] a;
    int idx_pool [4] = '{0, 1, 7, 31};
    reset = 1; req_valid = 0; req_we = 0; req_addr = '0; req_wdata = '0; req_wstrb = '0;
    resp_ready = 0;
    model_clear();
    repeat (3) @(negedge clock);
    chk("reset_outputs", 64'(all_vr()), 64'd0);
    reset = 0;
    @(negedge clock);
    chk("post_reset_idle", 64'(all_vr()), 64'h100);

    // cold load then repeat load
    do_req(32'h8000_0010, 0, '0, '0, 0, rd, lat);
    chk("cold_ar_addr_lit", 64'(last_ar), 64'h8000_0010);
    chk("cold_arlen_lit", 64'(last_arlen), 64'd1);
    chk("cold_rdata_lit", rd, 64'h1000_0002_4A5A_5A58);
    do_req(32'h8000_0010, 0, '0, '0, 0, rd, lat);
    chk("repeat_lat_lit", 64'(lat), 64'd2);
    chk("repeat_no_ar_lit", 64'(tx_ar), 64'd0);

    // partial store then reload
    do_req(32'h8000_0018, 1, 64'hAABB, 8'h03, 1, rd, lat);
    do_req(32'h8000_0018, 0, '0, '0, 0, rd, lat);
    chk("store_merge_lit", rd, 64'h1000_0003_4A5A_AABB);

    // fill the set with dirty lines; fifth evicts way 0
    for (int k = 1; k < 4; k++)
      do_req(32'h8000_0010 + 32'(k * 32'h200), 1, {$urandom, $urandom}, 8'hFF, 0, rd, lat);
    do_req(32'h8000_0810, 1, {$urandom, $urandom}, 8'hFF, 0, rd, lat);
    chk("evict_aw_lit", 64'(last_aw), 64'h8000_0010);
    chk("evict_awlen_lit", 64'(last_awlen), 64'd1);
    chk("evict_wbeats_lit", 64'(tx_w), 64'd2);
    chk("evict_ar_lit", 64'(last_ar), 64'h8000_0810);

    // stalled channels and a held response
    ar_stall = 5; aw_stall = 5; w_stall = 5;
    do_req(32'h8000_0A10, 1, 64'h0123_4567_89AB_CDEF, 8'hF0, 3, rd, lat);
    ar_stall = 0; aw_stall = 0; w_stall = 0;
    do_req(32'h8000_0A10, 0, '0, '0, 3, rd, lat);

    // reset while the second writeback beat is pending
    hold_beat1 = 1;
    predict(32'h8000_0C10, 1, 64'hFFFF, 8'hFF, hit, wb, exp_rd);
    req_addr = 32'h8000_0C10; req_we = 1; req_wdata = 64'hFFFF; req_wstrb = 8'hFF;
    req_valid = 1;
    n = 0;
    while (!req_ready && n < 50) begin @(negedge clock); n++; end
    @(negedge clock);
    req_valid = 0;
    n = 0;
    while (!(axi_wvalid && w_beat == 1) && n < 100) begin @(negedge clock); n++; end
    chk("reached_w_beat1", 64'(axi_wvalid && w_beat == 1), 64'd1);
    reset = 1;
    @(negedge clock);
    chk("mid_reset_outputs", 64'(all_vr()), 64'd0);
    reset = 0; hold_beat1 = 0;
    @(negedge clock);
    chk("after_mid_reset_idle", 64'(all_vr()), 64'h100);
    model_clear();
    gold.delete();
    foreach (mem[k]) gold[k] = mem[k];
    do_req(32'h8000_0810, 0, '0, '0, 0, rd, lat);
    chk("post_reset_miss_lit", 64'(tx_ar), 64'd1);

    // random traffic
    for (int t = 0; t < 250; t++) begin
      ar_stall = int'($urandom % 4); aw_stall = int'($urandom % 4); w_stall = int'($urandom % 4);
      a = 32'h8000_0000 + 32'(($urandom % 6) * 32'h200) + 32'(idx_pool[$urandom % 4] * 16)
          + 32'(($urandom % 2) * 8);
      do_req(a, 1'($urandom % 2), {$urandom, $urandom}, 8'($urandom), int'($urandom % 3), rd, lat);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired actual=running required=finished");
    $fatal(1);
  end
endmodule
